clock_victim_select: RTL and testbench

//  Replacement-victim picker for the 32-entry store. It sits directly downstream of the

---
 rtl/clock_vs_pkg.sv | 13 +
 rtl/clock_hand_ctr.sv | 36 +++
 rtl/clock_victim_select.sv | 129 ++++++++++++
 tb/tb_clock_victim_select.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_vs_pkg.sv
// Shared sizing and FSM state encoding for the clock (second-chance) victim picker.
package clock_vs_pkg;

  localparam int unsigned N_ENTRIES = 32;
  localparam int unsigned ADDR_W    = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {
    VS_IDLE = 2'd0,
    VS_SCAN = 2'd1,
    VS_DONE = 2'd2
  } vs_state_e;

endpackage

// File: rtl/clock_hand_ctr.sv
// Clock hand: a wrapping index counter. It can step by one, or jump to one past a loaded value.
module clock_hand_ctr
  import clock_vs_pkg::*;
#(
  parameter int unsigned W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] hand_o
);

  logic [W-1:0] hand_q, hand_d;

  always_comb begin
    hand_d = hand_q;
    if (load_i) begin
      hand_d = load_val_i + W'(1);
    end else if (inc_i) begin
      hand_d = hand_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hand_q <= '0;
    end else begin
      hand_q <= hand_d;
    end
  end

  assign hand_o = hand_q;

endmodule

// File: rtl/clock_victim_select.sv
// Second-chance victim selector over the classification bits, with a req/ack victim handshake.
// Defining CLOCK_VS_PERF_CNT_EN adds the evict_cnt/chance_cnt performance counters.
module clock_victim_select
  import clock_vs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 victim_req,
  input  logic                 victim_ack,
  input  logic [N_ENTRIES-1:0] valid_bits,
  input  logic [N_ENTRIES-1:0] class_bits,
  output logic                 victim_valid,
  output logic [ADDR_W-1:0]    victim_addr,
  output logic                 clr_en,
  output logic [ADDR_W-1:0]    clr_addr,
  output logic                 busy
`ifdef CLOCK_VS_PERF_CNT_EN
  ,
  output logic [31:0]          evict_cnt,
  output logic [31:0]          chance_cnt
`endif
);

  vs_state_e            state_q;
  logic [N_ENTRIES-1:0] passed_q;
  logic                 victim_valid_q;
  logic [ADDR_W-1:0]    victim_addr_q;
  logic                 clr_en_q;
  logic [ADDR_W-1:0]    clr_addr_q;
  logic                 busy_q;

  logic [ADDR_W-1:0]    hand;
  logic                 skip;
  logic                 hand_inc;
  logic                 hand_load;

  // The passed mask lets an entry that has already had its second chance win on the next lap.
  always_comb begin
    skip      = valid_bits[hand] & class_bits[hand] & ~passed_q[hand];
    hand_inc  = (state_q == VS_SCAN) && skip;
    hand_load = (state_q == VS_DONE) && victim_ack;
  end

  clock_hand_ctr #(
    .W (ADDR_W)
  ) u_hand (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (hand_inc),
    .load_i     (hand_load),
    .load_val_i (victim_addr_q),
    .hand_o     (hand)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= VS_IDLE;
      passed_q       <= '0;
      victim_valid_q <= 1'b0;
      victim_addr_q  <= '0;
      clr_en_q       <= 1'b0;
      clr_addr_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      clr_en_q <= 1'b0;
      case (state_q)
        VS_IDLE: begin
          if (victim_req) begin
            state_q  <= VS_SCAN;
            passed_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        VS_SCAN: begin
          if (skip) begin
            clr_en_q       <= 1'b1;
            clr_addr_q     <= hand;
            passed_q[hand] <= 1'b1;
          end else begin
            victim_addr_q  <= hand;
            victim_valid_q <= 1'b1;
            state_q        <= VS_DONE;
          end
        end
        VS_DONE: begin
          if (victim_ack) begin
            victim_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= VS_IDLE;
          end
        end
        default: begin
          state_q        <= VS_IDLE;
          victim_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_addr  = victim_addr_q;
  assign clr_en       = clr_en_q;
  assign clr_addr     = clr_addr_q;
  assign busy         = busy_q;

`ifdef CLOCK_VS_PERF_CNT_EN
  logic [31:0] evict_cnt_q;
  logic [31:0] chance_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      evict_cnt_q  <= '0;
      chance_cnt_q <= '0;
    end else begin
      if (hand_load) begin
        evict_cnt_q <= evict_cnt_q + 32'd1;
      end
      if (clr_en_q) begin
        chance_cnt_q <= chance_cnt_q + 32'd1;
      end
    end
  end

  assign evict_cnt  = evict_cnt_q;
  assign chance_cnt = chance_cnt_q;
`endif

endmodule

// File: tb/tb_clock_victim_select.sv
// Directed self-checking bench for clock_victim_select (counters checked when CLOCK_VS_PERF_CNT_EN is set).
module tb_clock_victim_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        victim_req;
  logic        victim_ack;
  logic [31:0] valid_bits;
  logic [31:0] class_bits;
  logic        victim_valid;
  logic [4:0]  victim_addr;
  logic        clr_en;
  logic [4:0]  clr_addr;
  logic        busy;
`ifdef CLOCK_VS_PERF_CNT_EN
  logic [31:0] evict_cnt;
  logic [31:0] chance_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  clock_victim_select dut (
    .clk          (clk),
    .rst          (rst),
    .victim_req   (victim_req),
    .victim_ack   (victim_ack),
    .valid_bits   (valid_bits),
    .class_bits   (class_bits),
    .victim_valid (victim_valid),
    .victim_addr  (victim_addr),
    .clr_en       (clr_en),
    .clr_addr     (clr_addr),
    .busy         (busy)
`ifdef CLOCK_VS_PERF_CNT_EN
    ,
    .evict_cnt    (evict_cnt),
    .chance_cnt   (chance_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit before driving or sampling.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    victim_req = 1'b0;
    victim_ack = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic ack_victim();
    victim_ack = 1'b1;
    step(1);
    victim_ack = 1'b0;
  endtask

  initial begin
    valid_bits = '1;
    class_bits = '0;
    do_reset();
    check("rst_vv",    32'(victim_valid), 32'd0);
    check("rst_vaddr", 32'(victim_addr),  32'd0);
    check("rst_clr",   32'(clr_en),       32'd0);
    check("rst_caddr", 32'(clr_addr),     32'd0);
    check("rst_busy",  32'(busy),         32'd0);

    // Unreferenced entries are taken immediately; the hand moves past the last victim.
    victim_req = 1'b1;
    step(1);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_vv0",  32'(victim_valid), 32'd0);
    victim_req = 1'b0;
    step(1);
    check("t2_vv",   32'(victim_valid), 32'd1);
    check("t2_addr", 32'(victim_addr),  32'd0);
    check("t2_clr",  32'(clr_en),       32'd0);
    ack_victim();
    check("t2_ackvv",   32'(victim_valid), 32'd0);
    check("t2_ackbusy", 32'(busy),         32'd0);
    victim_req = 1'b1;
    step(2);
    victim_req = 1'b0;
    check("t2_addr2", 32'(victim_addr), 32'd1);
    ack_victim();

    // Reset in the middle of a scan (hand=2 here) returns everything to idle with hand=0.
    class_bits = '1;
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    step(3);
    check("t1_midclr", 32'(clr_en), 32'd1);
    check("t1_midcad", 32'(clr_addr), 32'd4);
    do_reset();
    check("t1_vv",   32'(victim_valid), 32'd0);
    check("t1_clr",  32'(clr_en),       32'd0);
    check("t1_busy", 32'(busy),         32'd0);
    class_bits = '0;
    victim_req = 1'b1;
    step(2);
    victim_req = 1'b0;
    check("t1_hand0", 32'(victim_addr), 32'd0);
    check("t1_vv1",   32'(victim_valid), 32'd1);

    // Three referenced entries get a second chance each, then entry 3 is chosen.
    do_reset();
    class_bits = 32'h0000_0007;
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("t3_clr%0d", i),  32'(clr_en),   32'd1);
      check($sformatf("t3_cad%0d", i),  32'(clr_addr), 32'(i));
      check($sformatf("t3_vv%0d", i),   32'(victim_valid), 32'd0);
    end
    step(1);
    check("t3_clr_off", 32'(clr_en),       32'd0);
    check("t3_vv",      32'(victim_valid), 32'd1);
    check("t3_addr",    32'(victim_addr),  32'd3);
    ack_victim();

    // All referenced: a full lap of clears, then the start entry wins at edge 34.
    do_reset();
    class_bits = '1;
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      check($sformatf("t4_clr%0d", i), 32'(clr_en),   32'd1);
      check($sformatf("t4_cad%0d", i), 32'(clr_addr), 32'(i));
    end
    check("t4_vv_early", 32'(victim_valid), 32'd0);
    step(1);
    check("t4_vv",   32'(victim_valid), 32'd1);
    check("t4_addr", 32'(victim_addr),  32'd0);
    check("t4_clr",  32'(clr_en),       32'd0);
`ifdef CLOCK_VS_PERF_CNT_EN
    check("t4_chance", chance_cnt, 32'd32);
`endif
    ack_victim();
`ifdef CLOCK_VS_PERF_CNT_EN
    check("t4_evict", evict_cnt, 32'd1);
`endif

    // Invalid entry 5 is chosen regardless of its class bit; next scan starts at 6.
    do_reset();
    class_bits = '1;
    valid_bits = 32'hFFFF_FFDF;
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("t5_cad%0d", i), 32'(clr_addr), 32'(i));
    end
    step(1);
    check("t5_clr",  32'(clr_en),       32'd0);
    check("t5_vv",   32'(victim_valid), 32'd1);
    check("t5_addr", 32'(victim_addr),  32'd5);
    ack_victim();
    valid_bits = '1;
    class_bits = '0;
    victim_req = 1'b1;
    step(2);
    victim_req = 1'b0;
    check("t5_next", 32'(victim_addr), 32'd6);
    ack_victim();

    // Park the hand at 31: choose invalid entry 30 starting from hand=7.
    class_bits = '1;
    valid_bits = 32'hBFFF_FFFF;
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    begin
      int unsigned budget = 40;
      while (!victim_valid && budget != 0) begin
        step(1);
        budget--;
      end
      check("t6_setup_to", 32'(victim_valid), 32'd1);
    end
    check("t6_setup", 32'(victim_addr), 32'd30);
    ack_victim();

    // Ack in IDLE is ignored; scan from 31 wraps to 0.
    valid_bits = '1;
    class_bits = 32'h8000_0000;
    victim_ack = 1'b1;
    step(1);
    victim_ack = 1'b0;
    check("t6_idleack_busy", 32'(busy),         32'd0);
    check("t6_idleack_vv",   32'(victim_valid), 32'd0);
    victim_req = 1'b1;
    step(1);
    victim_req = 1'b0;
    step(1);
    check("t6_clr",  32'(clr_en),   32'd1);
    check("t6_cad",  32'(clr_addr), 32'd31);
    step(1);
    check("t6_vv",   32'(victim_valid), 32'd1);
    check("t6_addr", 32'(victim_addr),  32'd0);

    // req and ack together in DONE: ack wins, req is picked up on the following edge.
    class_bits = '0;
    victim_req = 1'b1;
    victim_ack = 1'b1;
    step(1);
    victim_ack = 1'b0;
    check("t7_vv",   32'(victim_valid), 32'd0);
    check("t7_busy", 32'(busy),         32'd0);
    step(1);
    victim_req = 1'b0;
    check("t7_busy2", 32'(busy), 32'd1);
    step(1);
    check("t7_addr", 32'(victim_addr),  32'd1);
    check("t7_vv2",  32'(victim_valid), 32'd1);
    ack_victim();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
